// File: rtl/mem_stage.sv
// ============================================================================
// Module   : mem_stage
// Purpose  : Memory-access stage of the five-stage pipeline. Holds the EX/MEM
//            pipeline register, runs the valid/allowin handshake toward EX and
//            WB, merges synchronous data-SRAM read data into the result
//            (byte/halfword extraction with sign/zero extension) and drives
//            the bypass tap for ID-stage hazard logic.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            EX_to_MEM_valid/bus - instruction offered by EX (75 bits)
//            data_sram_rdata     - SRAM read data for the load in MEM
//            WB_allowin          - WB can accept this cycle
//            MEM_allowin         - MEM can accept from EX this cycle
//            MEM_readygo         - MEM's instruction may leave this cycle
//            MEM_to_WB_valid/bus - instruction offered to WB (70 bits)
//            MEM_fwd_we/waddr/wdata - bypass tap
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        EX_to_MEM_valid,
  input  logic [74:0] EX_to_MEM_bus,
  input  logic [31:0] data_sram_rdata,
  input  logic        WB_allowin,
  output logic        MEM_allowin,
  output logic        MEM_readygo,
  output logic        MEM_to_WB_valid,
  output logic [69:0] MEM_to_WB_bus,
  output logic        MEM_fwd_we,
  output logic [4:0]  MEM_fwd_waddr,
  output logic [31:0] MEM_fwd_wdata
);

  // --------------------------------------------------------------------------
  // Stage state
  // --------------------------------------------------------------------------
  logic        r_mem_valid;
  logic [74:0] r_bus;
  logic        r_first_cycle;   // set during the first cycle an instruction sits in MEM
  logic [31:0] r_rdata_hold;    // SRAM data captured for use while stalled

  // --------------------------------------------------------------------------
  // Bus field decode
  // --------------------------------------------------------------------------
  logic [31:0] w_pc;
  logic [4:0]  w_load_op;       // one-hot {w,h,hu,b,bu}
  logic        w_rf_we;
  logic [4:0]  w_rf_waddr;
  logic [31:0] w_alu_result;
  logic [1:0]  w_off;

  assign w_pc         = r_bus[74:43];
  assign w_load_op    = r_bus[42:38];
  assign w_rf_we      = r_bus[37];
  assign w_rf_waddr   = r_bus[36:32];
  assign w_alu_result = r_bus[31:0];
  assign w_off        = w_alu_result[1:0];

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  // The SRAM answers one cycle after EX issues the request, so the data is
  // always present in the first MEM cycle and MEM never needs to wait.
  assign MEM_readygo     = 1'b1;
  assign MEM_allowin     = !r_mem_valid || (MEM_readygo && WB_allowin);
  assign MEM_to_WB_valid = r_mem_valid && MEM_readygo;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem_valid   <= 1'b0;
      r_bus         <= 75'd0;
      r_first_cycle <= 1'b0;
      r_rdata_hold  <= 32'd0;
    end else begin
      if (MEM_allowin) begin
        r_mem_valid <= EX_to_MEM_valid;
        if (EX_to_MEM_valid) begin
          r_bus         <= EX_to_MEM_bus;
          r_first_cycle <= 1'b1;
        end else begin
          r_first_cycle <= 1'b0;
        end
      end else begin
        r_first_cycle <= 1'b0;
      end

      // The SRAM output is only meaningful in the first cycle; keep a copy so
      // a stalled load keeps returning the same value.
      if (r_first_cycle) begin
        r_rdata_hold <= data_sram_rdata;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Load data extraction
  // --------------------------------------------------------------------------
  logic [31:0] w_rdata_eff;
  logic [15:0] w_half;
  logic [7:0]  w_byte;
  logic [31:0] w_final_result;

  assign w_rdata_eff = r_first_cycle ? data_sram_rdata : r_rdata_hold;

  // Halfword alignment is guaranteed upstream, so only off[1] selects.
  assign w_half = w_off[1] ? w_rdata_eff[31:16] : w_rdata_eff[15:0];

  always_comb begin
    w_byte = w_rdata_eff[7:0];
    case (w_off)
      2'd0:    w_byte = w_rdata_eff[7:0];
      2'd1:    w_byte = w_rdata_eff[15:8];
      2'd2:    w_byte = w_rdata_eff[23:16];
      default: w_byte = w_rdata_eff[31:24];
    endcase
  end

  // Priority w > h > hu > b > bu guards against malformed multi-hot encodings.
  always_comb begin
    w_final_result = w_alu_result;
    if (w_load_op[4]) begin
      w_final_result = w_rdata_eff;
    end else if (w_load_op[3]) begin
      w_final_result = {{16{w_half[15]}}, w_half};
    end else if (w_load_op[2]) begin
      w_final_result = {16'd0, w_half};
    end else if (w_load_op[1]) begin
      w_final_result = {{24{w_byte[7]}}, w_byte};
    end else if (w_load_op[0]) begin
      w_final_result = {24'd0, w_byte};
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // rf_we goes to WB unqualified; WB gates it with its own valid.
  assign MEM_to_WB_bus = {w_pc, w_rf_we, w_rf_waddr, w_final_result};

  assign MEM_fwd_we    = r_mem_valid && w_rf_we;
  assign MEM_fwd_waddr = w_rf_waddr;
  assign MEM_fwd_wdata = w_final_result;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none

module tb_mem_stage;

  logic        clk;
  logic        reset;
  logic        EX_to_MEM_valid;
  logic [74:0] EX_to_MEM_bus;
  logic [31:0] data_sram_rdata;
  logic        WB_allowin;
  logic        MEM_allowin;
  logic        MEM_readygo;
  logic        MEM_to_WB_valid;
  logic [69:0] MEM_to_WB_bus;
  logic        MEM_fwd_we;
  logic [4:0]  MEM_fwd_waddr;
  logic [31:0] MEM_fwd_wdata;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [4:0] OP_W  = 5'b10000;
  localparam logic [4:0] OP_H  = 5'b01000;
  localparam logic [4:0] OP_HU = 5'b00100;
  localparam logic [4:0] OP_B  = 5'b00010;
  localparam logic [4:0] OP_BU = 5'b00001;

  mem_stage dut (
    .clk             (clk),
    .reset           (reset),
    .EX_to_MEM_valid (EX_to_MEM_valid),
    .EX_to_MEM_bus   (EX_to_MEM_bus),
    .data_sram_rdata (data_sram_rdata),
    .WB_allowin      (WB_allowin),
    .MEM_allowin     (MEM_allowin),
    .MEM_readygo     (MEM_readygo),
    .MEM_to_WB_valid (MEM_to_WB_valid),
    .MEM_to_WB_bus   (MEM_to_WB_bus),
    .MEM_fwd_we      (MEM_fwd_we),
    .MEM_fwd_waddr   (MEM_fwd_waddr),
    .MEM_fwd_wdata   (MEM_fwd_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [74:0] mk_bus(input logic [31:0] pc, input logic [4:0] op,
                                         input logic we, input logic [4:0] wa,
                                         input logic [31:0] alu);
    return {pc, op, we, wa, alu};
  endfunction

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    EX_to_MEM_valid = 1'b0;
    EX_to_MEM_bus = '0;
    data_sram_rdata = 32'h0;
    WB_allowin = 1'b1;
    step();
    step();
    n_tests++;
    if (MEM_allowin !== 1'b1 || MEM_readygo !== 1'b1 || MEM_to_WB_valid !== 1'b0 ||
        MEM_to_WB_bus !== 70'd0 || MEM_fwd_we !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: got allowin=%b readygo=%b valid=%b bus=%h fwd_we=%b required 1 1 0 0 0",
               MEM_allowin, MEM_readygo, MEM_to_WB_valid, MEM_to_WB_bus, MEM_fwd_we);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if (MEM_allowin !== 1'b1 || MEM_to_WB_valid !== 1'b0 || MEM_fwd_we !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_cycle%0d: got allowin=%b valid=%b fwd_we=%b required 1 0 0",
                 i, MEM_allowin, MEM_to_WB_valid, MEM_fwd_we);
      end
    end
  endtask

  // Issue one instruction, present rdata in its first MEM cycle, check result.
  task automatic run_load(input string name, input logic [31:0] pc, input logic [4:0] op,
                          input logic [31:0] alu, input logic [31:0] rdata,
                          input logic [31:0] exp);
    WB_allowin = 1'b1;
    EX_to_MEM_valid = 1'b1;
    EX_to_MEM_bus = mk_bus(pc, op, 1'b1, 5'd3, alu);
    step();
    EX_to_MEM_valid = 1'b0;
    data_sram_rdata = rdata;
    #1;
    n_tests++;
    if (MEM_to_WB_valid !== 1'b1 || MEM_to_WB_bus[31:0] !== exp ||
        MEM_to_WB_bus[69:38] !== pc || MEM_fwd_wdata !== exp) begin
      n_fail++;
      $display("FAIL %s: got valid=%b pc=%h result=%h fwd=%h required valid=1 pc=%h result=%h",
               name, MEM_to_WB_valid, MEM_to_WB_bus[69:38], MEM_to_WB_bus[31:0],
               MEM_fwd_wdata, pc, exp);
    end
    step();
  endtask

  task automatic test_loads();
    run_load("ld_b",   32'h100, OP_B,  32'h1003, 32'h80FF1234, 32'hFFFFFF80);
    run_load("ld_bu",  32'h104, OP_BU, 32'h1003, 32'h80FF1234, 32'h00000080);
    run_load("ld_hu",  32'h108, OP_HU, 32'h2002, 32'hBEEF0000, 32'h0000BEEF);
    run_load("ld_h",   32'h10C, OP_H,  32'h2002, 32'hBEEF0000, 32'hFFFFBEEF);
    run_load("ld_b_o1",32'h110, OP_B,  32'h0001, 32'h000085AA, 32'hFFFFFF85);
    run_load("ld_bu_o2",32'h114,OP_BU, 32'h0002, 32'h00C30000, 32'h000000C3);
    run_load("ld_h_lo",32'h118, OP_H,  32'h0000, 32'h12347FFE, 32'h00007FFE);
    run_load("ld_w",   32'h11C, OP_W,  32'h0000, 32'h89ABCDEF, 32'h89ABCDEF);
    run_load("prio_w", 32'h120, 5'b11111, 32'h0003, 32'hF00DF00D, 32'hF00DF00D);
    run_load("prio_hu",32'h124, 5'b00111, 32'h0002, 32'h8001FF7F, 32'h00008001);
  endtask

  task automatic test_alu_op();
    WB_allowin = 1'b1;
    EX_to_MEM_valid = 1'b1;
    EX_to_MEM_bus = mk_bus(32'h200, 5'b0, 1'b1, 5'd5, 32'h12345678);
    step();
    EX_to_MEM_valid = 1'b0;
    data_sram_rdata = 32'hFFFFFFFF;
    #1;
    n_tests++;
    if (MEM_to_WB_bus !== {32'h200, 1'b1, 5'd5, 32'h12345678} || MEM_to_WB_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL alu_bus: got valid=%b bus=%h required valid=1 bus=%h",
               MEM_to_WB_valid, MEM_to_WB_bus, {32'h200, 1'b1, 5'd5, 32'h12345678});
    end
    n_tests++;
    if (MEM_fwd_we !== 1'b1 || MEM_fwd_waddr !== 5'd5 || MEM_fwd_wdata !== 32'h12345678) begin
      n_fail++;
      $display("FAIL alu_fwd: got we=%b waddr=%0d wdata=%h required 1 5 12345678",
               MEM_fwd_we, MEM_fwd_waddr, MEM_fwd_wdata);
    end
    step();
    n_tests++;
    if (MEM_to_WB_valid !== 1'b0 || MEM_fwd_we !== 1'b0) begin
      n_fail++;
      $display("FAIL alu_drain: got valid=%b fwd_we=%b required 0 0", MEM_to_WB_valid, MEM_fwd_we);
    end
  endtask

  task automatic test_stall();
    WB_allowin = 1'b1;
    EX_to_MEM_valid = 1'b1;
    EX_to_MEM_bus = mk_bus(32'h300, OP_W, 1'b1, 5'd7, 32'h4000);
    step();
    EX_to_MEM_valid = 1'b1;                       // a follower waits in EX
    EX_to_MEM_bus = mk_bus(32'h304, 5'b0, 1'b1, 5'd8, 32'h55);
    data_sram_rdata = 32'hCAFEF00D;
    WB_allowin = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (MEM_allowin !== 1'b0 || MEM_to_WB_bus[31:0] !== 32'hCAFEF00D ||
          MEM_to_WB_bus[69:38] !== 32'h300 || MEM_to_WB_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_cycle%0d: got allowin=%b valid=%b pc=%h result=%h required 0 1 300 cafef00d",
                 i, MEM_allowin, MEM_to_WB_valid, MEM_to_WB_bus[69:38], MEM_to_WB_bus[31:0]);
      end
      step();
      data_sram_rdata = 32'hDEADBEEF;
      #1;
    end
    WB_allowin = 1'b1;
    #1;
    n_tests++;
    if (MEM_allowin !== 1'b1 || MEM_to_WB_valid !== 1'b1 || MEM_to_WB_bus[31:0] !== 32'hCAFEF00D) begin
      n_fail++;
      $display("FAIL stall_release: got allowin=%b valid=%b result=%h required 1 1 cafef00d",
               MEM_allowin, MEM_to_WB_valid, MEM_to_WB_bus[31:0]);
    end
    step();
    EX_to_MEM_valid = 1'b0;
    #1;
    n_tests++;
    if (MEM_to_WB_valid !== 1'b1 || MEM_to_WB_bus[69:38] !== 32'h304 ||
        MEM_to_WB_bus[31:0] !== 32'h55) begin
      n_fail++;
      $display("FAIL stall_follower: got valid=%b pc=%h result=%h required 1 304 55",
               MEM_to_WB_valid, MEM_to_WB_bus[69:38], MEM_to_WB_bus[31:0]);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] pcs [4];
    pcs[0] = 32'h400; pcs[1] = 32'h404; pcs[2] = 32'h408; pcs[3] = 32'h40C;
    WB_allowin = 1'b1;
    EX_to_MEM_valid = 1'b1;
    EX_to_MEM_bus = mk_bus(pcs[0], 5'b0, 1'b1, 5'd1, 32'hA0);
    for (int i = 0; i < 4; i++) begin
      step();
      if (i < 3) EX_to_MEM_bus = mk_bus(pcs[i+1], 5'b0, 1'b1, 5'(i + 2), 32'hA0 + 32'(i + 1));
      else       EX_to_MEM_valid = 1'b0;
      #1;
      n_tests++;
      if (MEM_to_WB_valid !== 1'b1 || MEM_to_WB_bus[69:38] !== pcs[i] ||
          MEM_to_WB_bus[31:0] !== 32'hA0 + 32'(i) || MEM_allowin !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_%0d: got valid=%b pc=%h result=%h allowin=%b required 1 %h %h 1",
                 i, MEM_to_WB_valid, MEM_to_WB_bus[69:38], MEM_to_WB_bus[31:0], MEM_allowin,
                 pcs[i], 32'hA0 + 32'(i));
      end
    end
    step();
    n_tests++;
    if (MEM_to_WB_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain: got valid=%b required 0", MEM_to_WB_valid);
    end
  endtask

  task automatic test_reset_mid_stream();
    WB_allowin = 1'b1;
    EX_to_MEM_valid = 1'b1;
    EX_to_MEM_bus = mk_bus(32'h500, 5'b0, 1'b1, 5'd9, 32'h1);
    for (int i = 0; i < 3; i++) begin
      step();
      EX_to_MEM_bus = mk_bus(32'h504 + 32'(4 * i), 5'b0, 1'b1, 5'd9, 32'h2);
    end
    // third instruction now in MEM, a fourth offered; stall it and reset
    WB_allowin = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    EX_to_MEM_valid = 1'b0;
    WB_allowin = 1'b1;
    #1;
    n_tests++;
    if (MEM_to_WB_valid !== 1'b0 || MEM_to_WB_bus !== 70'd0 || MEM_fwd_we !== 1'b0 ||
        MEM_allowin !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_stream: got valid=%b bus=%h fwd_we=%b allowin=%b required 0 0 0 1",
               MEM_to_WB_valid, MEM_to_WB_bus, MEM_fwd_we, MEM_allowin);
    end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_alu_op();
    test_stall();
    test_back_to_back();
    test_reset_mid_stream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage pipeline, between the execute stage and `wb_stage`. It owns the EX/MEM pipeline register and the valid/allowin handshake on both sides. It merges the synchronous data-SRAM read data into the result, extracting and extending bytes and halfwords for loads. It produces the 70-bit bus `wb_stage` consumes, plus a bypass tap for ID-stage hazard logic.

## Interface
Parameters:
- none (all widths fixed by the pipeline bus formats)

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `EX_to_MEM_valid`  in  1  execute stage offers an instruction
- `EX_to_MEM_bus`  in  75  {pc[74:43], load_op[42:38], rf_we[37], rf_waddr[36:32], alu_result[31:0]}; load_op one-hot {w,h,hu,b,bu} at bits 42..38
- `data_sram_rdata`  in  32  SRAM read data; valid only in the first cycle a load occupies MEM
- `WB_allowin`  in  1  WB can accept this cycle
- `MEM_allowin`  out  1  MEM can accept from EX this cycle
- `MEM_readygo`  out  1  MEM's instruction may leave this cycle
- `MEM_to_WB_valid`  out  1  valid offered to WB
- `MEM_to_WB_bus`  out  70  {pc[69:38], rf_we[37], rf_waddr[36:32], final_result[31:0]}
- `MEM_fwd_we`  out  1  MEM_valid && rf_we
- `MEM_fwd_waddr`  out  5  destination register
- `MEM_fwd_wdata`  out  32  final_result (same value as the bus)

## Operation
- State: `MEM_valid`, `bus_r[74:0]`, `first_cycle`, `rdata_hold[31:0]`.
- `MEM_readygo = 1` always: the SRAM returns data one cycle after the request is issued in EX.
- `MEM_allowin = !MEM_valid || (MEM_readygo && WB_allowin)`.
- If `MEM_allowin` is high:
  - `MEM_valid <= EX_to_MEM_valid`.
  - If `EX_to_MEM_valid` is also high: `bus_r <= EX_to_MEM_bus` and `first_cycle <= 1`.
- Otherwise (stalled): `first_cycle <= 0`.
- Read-data selection:
  - Whenever `first_cycle` is set: `rdata_hold <= data_sram_rdata`.
  - Effective read data: `rdata_eff = first_cycle ? data_sram_rdata : rdata_hold`.
- Load extraction uses `off = alu_result[1:0]`:
  - w: `rdata_eff`.
  - h / hu: halfword `rdata_eff[off[1]*16 +: 16]`, sign- / zero-extended. `off[0]` is ignored; alignment is checked upstream.
  - b / bu: byte `rdata_eff[off*8 +: 8]`, sign- / zero-extended.
  - load_op == 0: `final_result = alu_result`.
  - Multiple load_op bits set: priority w > h > hu > b > bu.
- `MEM_to_WB_valid = MEM_valid && MEM_readygo`.
- `MEM_to_WB_bus = {pc, rf_we, rf_waddr, final_result}` from `bus_r`.
  - `rf_we` is passed unqualified; WB gates it with valid.
- The MEM/WB register lives downstream of this block. Outputs here are combinational from MEM state and `data_sram_rdata`.

## Timing
- Latency: an instruction accepted at edge N is presented to WB in cycle N+1. With `WB_allowin=1` it leaves at edge N+1. Throughput is 1 instruction/cycle.
- Reset values (after reset edge):
  - `MEM_valid=0`, `first_cycle=0`, `bus_r=0`, `rdata_hold=0`.
  - Hence `MEM_allowin=1`, `MEM_readygo=1`, `MEM_to_WB_valid=0`, `MEM_to_WB_bus=0`, `MEM_fwd_we=0`.
- Stall: while `WB_allowin=0` and `MEM_valid=1`:
  - `bus_r` is frozen.
  - From the second cycle on, the load result comes from `rdata_hold`, so SRAM output changes are ignored.
- Simultaneous leave and enter (`MEM_valid`, `WB_allowin`, `EX_to_MEM_valid` all 1): new instruction is captured and `first_cycle` re-arms, with no bubble.
- `MEM_valid=0` with `EX_to_MEM_valid=0`: stays empty. `bus_r` may update or hold; it is don't-care because valid is 0.
- Reset mid-stall: the instruction is dropped and the outputs return to their reset values on the next edge.

## Test plan
- Reset, then hold `EX_to_MEM_valid=0` for 3 cycles -> `MEM_allowin=1`, `MEM_to_WB_valid=0`, `MEM_fwd_we=0` every cycle.
- ld.b, alu_result=0x1003, rdata=0x80FF1234 -> final_result=0xFFFFFF80. Same access as ld.bu -> 0x00000080.
- ld.hu, alu_result=0x2002, rdata=0xBEEF0000 -> 0x0000BEEF. ld.h with the same access -> 0xFFFFBEEF.
- add (load_op=0), alu_result=0x12345678, rf_we=1, rf_waddr=5 -> bus={pc,1,5,0x12345678}, `MEM_fwd_we=1`, `MEM_fwd_waddr=5` in the same cycle.
- ld.w enters with rdata=0xCAFEF00D, then `WB_allowin=0` for 2 cycles while rdata changes to 0xDEADBEEF:
  - `MEM_allowin=0` both cycles.
  - final_result stays 0xCAFEF00D.
  - Leaves on the cycle `WB_allowin` returns to 1.
- Four back-to-back instructions with `WB_allowin=1` -> four consecutive `MEM_to_WB_valid` cycles, correct pcs in order. Assert `reset` during the third -> `MEM_to_WB_valid=0` the next cycle.
